decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parameterised RV32 instruction decode stage that generates the datapath control word, register indices, sign-extended immediate and memory access attributes. It sits between instruction fetch and the execute/ALU stage. It uses a valid/ready handshake with a 2-entry skid buffer, so it can stall without combinational ready paths. It also supports flush and optional RV32M and sub-word load/store decode. No output is ever driven to z/x; fields that are unused for a class are 0.

## Interface
- EN_M, default 0: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 flags those encodings illegal.
- EN_SUBWORD, default 1: 1 decodes lb/lh/lbu/lhu/sb/sh; 0 accepts only lw/sw.
- PC_W, default 32: width of the pc sideband.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all buffered entries and the current input beat
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; equals !skid_valid (registered source)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded word valid
- out_ready  in  1  execute accepts
- out_pc  out  PC_W  pc of the decoded instruction
- ALUop  out  5  ALU operation code (encoding under Operation)
- PC_src, JT, reg_rd, reg_wr, wr_rd, mem_en, pc_r, alu_dt  out  1 each  datapath controls
- mem_alu  out  2  writeback select: 0 pc+4, 1 auipc sum, 2 lui imm, 3 ALU
- alu_src  out  2  operand-B select: 0 rs2, 1 I-imm, 2 S-imm
- rs1, rs2, rd  out  5 each  register indices, taken from instr[19:15], instr[24:20], instr[11:7]
- imm  out  32  sign-extended immediate, formatted per instruction type (I/S/B/U/J)
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_unsigned  out  1  1 for lbu/lhu
- illegal  out  1  unsupported or malformed encoding

## Operation
- ALUop codes: 1 add, 2 sub, 3 or, 4 and, 5 xor, 6 sll, 7 srl, 8 sra, 9 slt, 10 beq, 11 bne, 12 blt, 13 bge, 14 jalr, 15 sltu, 16 bltu, 17 bgeu, 18–25 mul/mulh/mulhsu/mulhu/div/divu/rem/remu, 0 none.
- R-type (0110011):
  - Controls: reg_rd=1, reg_wr=1, mem_alu=3, alu_src=0.
  - funct7 must be 0000000. The only exceptions are 0100000 for sub/sra, and 0000001 for M ops when EN_M=1.
- OP-IMM (0010011): same controls as R-type but alu_src=1. slli/srli require funct7=0000000, srai requires 0100000; any other funct7 is illegal. sltiu gives ALUop=15.
- Load (0000011): ALUop=1, reg_rd=1, reg_wr=1, pc_r=1, alu_src=1, alu_dt=1, mem_en=1, mem_alu=0. mem_size and mem_unsigned come from funct3.
- Store (0100011): ALUop=1, reg_rd=1, wr_rd=1, pc_r=1, alu_src=2, mem_en=1.
- Branch (1100011): reg_rd=1, alu_src=0. ALUop from funct3: 000→10, 001→11, 100→12, 101→13, 110→16, 111→17. funct3 010/011 is illegal.
- jal: PC_src=1, reg_wr=1, mem_alu=0.
- jalr (funct3 000 only): ALUop=14, JT=1, reg_rd=1, reg_wr=1, alu_src=1, mem_alu=0.
- lui: reg_wr=1, mem_alu=2.
- auipc: ALUop=1, reg_wr=1, mem_alu=1.
- Illegal encoding: illegal=1 and every control output is 0, including reg_wr, wr_rd and mem_en. The entry still flows through the handshake (out_valid=1) with pc and indices intact.
- Buffer: main register M plus skid register S.
  - An accepted beat (in_valid & in_ready) is written into M if M is empty or M drains in the same cycle; otherwise it goes into S.
  - When M drains while S is full, S moves to M.
  - Ordering is strictly FIFO.

## Timing
- Reset: out_valid=0, skid_valid=0, in_ready=1. All decoded outputs reset to 0 and out_pc=0.
- Latency: 1 cycle from accept to out_valid when M is empty or draining.
- Throughput: 1 instruction/cycle while out_ready=1.
- Stall: outputs hold stable while out_valid & !out_ready.
  - The first beat accepted during a stall fills S; in_ready drops the next cycle.
  - in_ready returns to 1 the cycle after S empties.
- Simultaneous accept and drain with S full: cannot occur, since in_ready=0.
- Simultaneous accept and drain with S empty: the new beat replaces M and no bubble is inserted.
- Flush: the next cycle has out_valid=0 and skid_valid=0. The beat offered in the flush cycle is dropped. in_ready=1 in the cycle after flush.
- Flush has priority over accept and drain in the same cycle.
- Reset asserted mid-stream clears both entries immediately (asynchronous); no partial output is emitted after release.

## Test plan
- add x3,x1,x2 (0x002081B3) with out_ready=1 → one cycle later: out_valid=1, ALUop=1, rd=3, rs1=1, rs2=2, reg_wr=1, mem_alu=3, illegal=0.
- Back-to-back lw x5,-4(x2) (0xFFC12283) then sw: hold out_ready=0 for 3 cycles, then set it to 1.
  - lw output: imm=0xFFFFFFFC, alu_dt=1, mem_size=2.
  - in_ready=0 after the second beat is accepted.
  - Both instructions emerge in order with no loss or duplication.
- bgeu x1,x2,+8 (0x0020F463) → ALUop=17, imm=8, reg_wr=0. With EN_M=0, mul (0x022081B3) → illegal=1 with all controls 0; with EN_M=1 → ALUop=18.
- Assert flush while M and S are both full and a new beat is offered → the next cycle has out_valid=0 and in_ready=1, and none of the three instructions ever appears.
- Assert reset asynchronously mid-stall → out_valid drops without waiting for a clock edge. After release, the first new instruction appears with 1-cycle latency.
- Random legal/illegal stream with a random out_ready pattern, checked against a reference decoder → exact match and FIFO order preserved.

Source files
------------

// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode of the incoming word, captured into a
// two-entry (main + skid) buffer so that in_ready comes straight from a flop.
module decode_stage #(
  parameter bit EN_M       = 1'b0,
  parameter bit EN_SUBWORD = 1'b1,
  parameter int PC_W       = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      ALUop,
  output logic            PC_src,
  output logic            JT,
  output logic            reg_rd,
  output logic            reg_wr,
  output logic            wr_rd,
  output logic            mem_en,
  output logic            pc_r,
  output logic            alu_dt,
  output logic [1:0]      mem_alu,
  output logic [1:0]      alu_src,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic [1:0]      mem_size,
  output logic            mem_unsigned,
  output logic            illegal,
  output logic            skid_valid
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_JALR = 5'd14;
  localparam logic [4:0] ALU_MUL  = 5'd18;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic        pc_src;
    logic        jt;
    logic        reg_rd;
    logic        reg_wr;
    logic        wr_rd;
    logic        mem_en;
    logic        pc_r;
    logic        alu_dt;
    logic [1:0]  mem_alu;
    logic [1:0]  alu_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;
  } dec_t;

  // ALU code for the funct7=0000000 register/immediate arithmetic group.
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = 5'd1;
      3'b001:  alu_base = 5'd6;
      3'b010:  alu_base = 5'd9;
      3'b011:  alu_base = 5'd15;
      3'b100:  alu_base = 5'd5;
      3'b101:  alu_base = 5'd7;
      3'b110:  alu_base = 5'd3;
      default: alu_base = 5'd4;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  dec_t        dec;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_rd  = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.mem_alu = 2'd3;
        if (f7 == 7'b0000000) begin
          legal      = 1'b1;
          dec.alu_op = alu_base(f3);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal      = 1'b1;
          dec.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if (EN_M && f7 == 7'b0000001) begin
          legal      = 1'b1;
          dec.alu_op = ALU_MUL + {2'b00, f3};
        end
      end
      OP_IMM: begin
        dec.reg_rd  = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.mem_alu = 2'd3;
        dec.alu_src = 2'd1;
        dec.imm     = imm_i;
        case (f3)
          3'b001: begin
            legal      = (f7 == 7'b0000000);
            dec.alu_op = ALU_SLL;
          end
          3'b101: begin
            legal      = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec.alu_op = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
          end
          default: begin
            legal      = 1'b1;
            dec.alu_op = alu_base(f3);
          end
        endcase
      end
      OP_LOAD: begin
        dec.alu_op       = ALU_ADD;
        dec.reg_rd       = 1'b1;
        dec.reg_wr       = 1'b1;
        dec.pc_r         = 1'b1;
        dec.alu_src      = 2'd1;
        dec.alu_dt       = 1'b1;
        dec.mem_en       = 1'b1;
        dec.imm          = imm_i;
        dec.mem_size     = f3[1:0];
        dec.mem_unsigned = f3[2];
        case (f3)
          3'b010:                         legal = 1'b1;
          3'b000, 3'b001, 3'b100, 3'b101: legal = EN_SUBWORD;
          default:                        legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.alu_op   = ALU_ADD;
        dec.reg_rd   = 1'b1;
        dec.wr_rd    = 1'b1;
        dec.pc_r     = 1'b1;
        dec.alu_src  = 2'd2;
        dec.mem_en   = 1'b1;
        dec.imm      = imm_s;
        dec.mem_size = f3[1:0];
        case (f3)
          3'b010:         legal = 1'b1;
          3'b000, 3'b001: legal = EN_SUBWORD;
          default:        legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        dec.reg_rd = 1'b1;
        dec.imm    = imm_b;
        legal      = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = 5'd10;
          3'b001:  dec.alu_op = 5'd11;
          3'b100:  dec.alu_op = 5'd12;
          3'b101:  dec.alu_op = 5'd13;
          3'b110:  dec.alu_op = 5'd16;
          3'b111:  dec.alu_op = 5'd17;
          default: legal      = 1'b0;
        endcase
      end
      OP_JAL: begin
        legal      = 1'b1;
        dec.pc_src = 1'b1;
        dec.reg_wr = 1'b1;
        dec.imm    = imm_j;
      end
      OP_JALR: begin
        legal       = (f3 == 3'b000);
        dec.alu_op  = ALU_JALR;
        dec.jt      = 1'b1;
        dec.reg_rd  = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.alu_src = 2'd1;
        dec.imm     = imm_i;
      end
      OP_LUI: begin
        legal       = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.mem_alu = 2'd2;
        dec.imm     = imm_u;
      end
      OP_AUIPC: begin
        legal       = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.reg_wr  = 1'b1;
        dec.mem_alu = 2'd1;
        dec.imm     = imm_u;
      end
      default: legal = 1'b0;
    endcase
    // An illegal word carries no side effects downstream, only its flag and indices.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
  end

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and in_ready is a flop output (no comb path from out_ready).
  logic            m_valid, s_valid;
  dec_t            m_dec, s_dec;
  logic [PC_W-1:0] m_pc, s_pc;
  logic            accept, drain;

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_dec   <= '0;
      s_dec   <= '0;
      m_pc    <= '0;
      s_pc    <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (drain) begin
      if (s_valid) begin
        m_dec   <= s_dec;
        m_pc    <= s_pc;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_dec <= dec;
        m_pc  <= in_pc;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!m_valid) begin
        m_valid <= 1'b1;
        m_dec   <= dec;
        m_pc    <= in_pc;
      end else begin
        s_valid <= 1'b1;
        s_dec   <= dec;
        s_pc    <= in_pc;
      end
    end
  end

  assign out_valid    = m_valid;
  assign skid_valid   = s_valid;
  assign out_pc       = m_pc;
  assign ALUop        = m_dec.alu_op;
  assign PC_src       = m_dec.pc_src;
  assign JT           = m_dec.jt;
  assign reg_rd       = m_dec.reg_rd;
  assign reg_wr       = m_dec.reg_wr;
  assign wr_rd        = m_dec.wr_rd;
  assign mem_en       = m_dec.mem_en;
  assign pc_r         = m_dec.pc_r;
  assign alu_dt       = m_dec.alu_dt;
  assign mem_alu      = m_dec.mem_alu;
  assign alu_src      = m_dec.alu_src;
  assign rs1          = m_dec.rs1;
  assign rs2          = m_dec.rs2;
  assign rd           = m_dec.rd;
  assign imm          = m_dec.imm;
  assign mem_size     = m_dec.mem_size;
  assign mem_unsigned = m_dec.mem_unsigned;
  assign illegal      = m_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one EN_M=0 instance (main) and one EN_M=1
// instance sharing the same stimulus for the RV32M check.
module tb_decode_stage;

  logic        clock, reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, skid_valid;
  logic [31:0] out_pc, imm;
  logic [4:0]  ALUop, rs1, rs2, rd;
  logic        PC_src, JT, reg_rd, reg_wr, wr_rd, mem_en, pc_r, alu_dt, mem_unsigned, illegal;
  logic [1:0]  mem_alu, alu_src, mem_size;

  logic        m_in_ready, m_out_valid, m_skid_valid;
  logic [31:0] m_out_pc, m_imm;
  logic [4:0]  m_ALUop, m_rs1, m_rs2, m_rd;
  logic        m_PC_src, m_JT, m_reg_rd, m_reg_wr, m_wr_rd, m_mem_en, m_pc_r, m_alu_dt;
  logic        m_mem_unsigned, m_illegal;
  logic [1:0]  m_mem_alu, m_alu_src, m_mem_size;

  logic [14:0] ctrl;
  assign ctrl = {PC_src, JT, reg_rd, reg_wr, wr_rd, mem_en, pc_r, alu_dt,
                 mem_alu, alu_src, mem_size, mem_unsigned};

  int n_pass = 0;
  int n_total = 0;

  decode_stage #(.EN_M(1'b0), .EN_SUBWORD(1'b1), .PC_W(32)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .ALUop(ALUop), .PC_src(PC_src), .JT(JT), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .wr_rd(wr_rd), .mem_en(mem_en), .pc_r(pc_r), .alu_dt(alu_dt),
    .mem_alu(mem_alu), .alu_src(alu_src), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .illegal(illegal),
    .skid_valid(skid_valid)
  );

  decode_stage #(.EN_M(1'b1), .EN_SUBWORD(1'b1), .PC_W(32)) dut_m (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .ALUop(m_ALUop), .PC_src(m_PC_src), .JT(m_JT), .reg_rd(m_reg_rd),
    .reg_wr(m_reg_wr), .wr_rd(m_wr_rd), .mem_en(m_mem_en), .pc_r(m_pc_r), .alu_dt(m_alu_dt),
    .mem_alu(m_mem_alu), .alu_src(m_alu_src), .rs1(m_rs1), .rs2(m_rs2), .rd(m_rd),
    .imm(m_imm), .mem_size(m_mem_size), .mem_unsigned(m_mem_unsigned), .illegal(m_illegal),
    .skid_valid(m_skid_valid)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hand-decoded instruction table for the streaming test.
  localparam int N = 14;
  logic [31:0] t_instr[N];
  logic [4:0]  t_alu[N];
  logic [14:0] t_ctrl[N];
  logic [31:0] t_imm[N];
  logic        t_ill[N];
  logic [31:0] exp_q[$];

  task automatic init_table();
    t_instr[0]  = 32'h002081B3; t_alu[0]  = 5'd1;  t_ctrl[0]  = 15'b0_0_1_1_0_0_0_0_11_00_00_0; t_imm[0]  = 32'h0;        t_ill[0]  = 1'b0;
    t_instr[1]  = 32'hFFC12283; t_alu[1]  = 5'd1;  t_ctrl[1]  = 15'b0_0_1_1_0_1_1_1_00_01_10_0; t_imm[1]  = 32'hFFFFFFFC; t_ill[1]  = 1'b0;
    t_instr[2]  = 32'h00512423; t_alu[2]  = 5'd1;  t_ctrl[2]  = 15'b0_0_1_0_1_1_1_0_00_10_10_0; t_imm[2]  = 32'h8;        t_ill[2]  = 1'b0;
    t_instr[3]  = 32'h0020F463; t_alu[3]  = 5'd17; t_ctrl[3]  = 15'b0_0_1_0_0_0_0_0_00_00_00_0; t_imm[3]  = 32'h8;        t_ill[3]  = 1'b0;
    t_instr[4]  = 32'h022081B3; t_alu[4]  = 5'd0;  t_ctrl[4]  = 15'b0;                          t_imm[4]  = 32'h0;        t_ill[4]  = 1'b1;
    t_instr[5]  = 32'h0030C303; t_alu[5]  = 5'd1;  t_ctrl[5]  = 15'b0_0_1_1_0_1_1_1_00_01_00_1; t_imm[5]  = 32'h3;        t_ill[5]  = 1'b0;
    t_instr[6]  = 32'h409453B3; t_alu[6]  = 5'd8;  t_ctrl[6]  = 15'b0_0_1_1_0_0_0_0_11_00_00_0; t_imm[6]  = 32'h0;        t_ill[6]  = 1'b0;
    t_instr[7]  = 32'h00000000; t_alu[7]  = 5'd0;  t_ctrl[7]  = 15'b0;                          t_imm[7]  = 32'h0;        t_ill[7]  = 1'b1;
    t_instr[8]  = 32'h010000EF; t_alu[8]  = 5'd0;  t_ctrl[8]  = 15'b1_0_0_1_0_0_0_0_00_00_00_0; t_imm[8]  = 32'h10;       t_ill[8]  = 1'b0;
    t_instr[9]  = 32'h123452B7; t_alu[9]  = 5'd0;  t_ctrl[9]  = 15'b0_0_0_1_0_0_0_0_10_00_00_0; t_imm[9]  = 32'h12345000; t_ill[9]  = 1'b0;
    t_instr[10] = 32'h00001317; t_alu[10] = 5'd1;  t_ctrl[10] = 15'b0_0_0_1_0_0_0_0_01_00_00_0; t_imm[10] = 32'h1000;     t_ill[10] = 1'b0;
    t_instr[11] = 32'h00008067; t_alu[11] = 5'd14; t_ctrl[11] = 15'b0_1_1_1_0_0_0_0_00_01_00_0; t_imm[11] = 32'h0;        t_ill[11] = 1'b0;
    t_instr[12] = 32'hFFF00093; t_alu[12] = 5'd1;  t_ctrl[12] = 15'b0_0_1_1_0_0_0_0_11_01_00_0; t_imm[12] = 32'hFFFFFFFF; t_ill[12] = 1'b0;
    t_instr[13] = 32'h0020A463; t_alu[13] = 5'd0;  t_ctrl[13] = 15'b0;                          t_imm[13] = 32'h0;        t_ill[13] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) step();
    n_total++;
    if ({out_valid, skid_valid, in_ready} !== 3'b001)
      $display("FAIL reset_handshake got=%b exp=001", {out_valid, skid_valid, in_ready});
    else n_pass++;
    n_total++;
    if ({ALUop, ctrl, imm, out_pc, illegal, rd} !== '0)
      $display("FAIL reset_fields alu=%0d ctrl=%b imm=%h pc=%h ill=%b rd=%0d exp=all_zero",
               ALUop, ctrl, imm, out_pc, illegal, rd);
    else n_pass++;
    reset = 1'b0;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_release_valid got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, ALUop, rd, rs1, rs2, reg_wr, mem_alu, illegal, out_pc} !==
        {1'b1, 5'd1, 5'd3, 5'd1, 5'd2, 1'b1, 2'd3, 1'b0, 32'h100})
      $display("FAIL add got v=%b alu=%0d rd=%0d rs1=%0d rs2=%0d wr=%b ma=%0d ill=%b pc=%h exp v=1 alu=1 rd=3 rs1=1 rs2=2 wr=1 ma=3 ill=0 pc=100",
               out_valid, ALUop, rd, rs1, rs2, reg_wr, mem_alu, illegal, out_pc);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL add_drain got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFC12283; in_pc = 32'h200;
    step();
    n_total++;
    if ({out_valid, imm, alu_dt, mem_size, mem_en, rd, in_ready} !==
        {1'b1, 32'hFFFFFFFC, 1'b1, 2'd2, 1'b1, 5'd5, 1'b1})
      $display("FAIL lw got v=%b imm=%h dt=%b sz=%0d men=%b rd=%0d rdy=%b exp v=1 imm=fffffffc dt=1 sz=2 men=1 rd=5 rdy=1",
               out_valid, imm, alu_dt, mem_size, mem_en, rd, in_ready);
    else n_pass++;
    in_instr = 32'h00512423; in_pc = 32'h204;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({in_ready, skid_valid, out_valid, out_pc} !== {1'b0, 1'b1, 1'b1, 32'h200})
      $display("FAIL skid_fill got rdy=%b skid=%b v=%b pc=%h exp rdy=0 skid=1 v=1 pc=200",
               in_ready, skid_valid, out_valid, out_pc);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, out_pc, imm, ctrl} !== {1'b1, 32'h200, 32'hFFFFFFFC, 15'b0_0_1_1_0_1_1_1_00_01_10_0})
      $display("FAIL stall_hold got v=%b pc=%h imm=%h ctrl=%b exp v=1 pc=200 imm=fffffffc",
               out_valid, out_pc, imm, ctrl);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_total++;
    if ({out_valid, out_pc, imm, wr_rd, reg_wr, alu_src, skid_valid, in_ready} !==
        {1'b1, 32'h204, 32'h8, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1})
      $display("FAIL sw_after_stall got v=%b pc=%h imm=%h wrd=%b wr=%b src=%0d skid=%b rdy=%b exp v=1 pc=204 imm=8 wrd=1 wr=0 src=2 skid=0 rdy=1",
               out_valid, out_pc, imm, wr_rd, reg_wr, alu_src, skid_valid, in_ready);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_no_dup got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_branch_mul();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0020F463; in_pc = 32'h300;
    step();
    n_total++;
    if ({out_valid, ALUop, imm, reg_wr, illegal, out_pc} !== {1'b1, 5'd17, 32'h8, 1'b0, 1'b0, 32'h300})
      $display("FAIL bgeu got v=%b alu=%0d imm=%h wr=%b ill=%b pc=%h exp v=1 alu=17 imm=8 wr=0 ill=0 pc=300",
               out_valid, ALUop, imm, reg_wr, illegal, out_pc);
    else n_pass++;
    in_instr = 32'h022081B3; in_pc = 32'h304;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, illegal, ALUop, ctrl, imm, rd, rs1, rs2, out_pc} !==
        {1'b1, 1'b1, 5'd0, 15'd0, 32'd0, 5'd3, 5'd1, 5'd2, 32'h304})
      $display("FAIL mul_no_m got v=%b ill=%b alu=%0d ctrl=%b imm=%h rd=%0d rs1=%0d rs2=%0d pc=%h exp v=1 ill=1 alu=0 ctrl=0 imm=0 rd=3 rs1=1 rs2=2 pc=304",
               out_valid, illegal, ALUop, ctrl, imm, rd, rs1, rs2, out_pc);
    else n_pass++;
    n_total++;
    if ({m_out_valid, m_illegal, m_ALUop, m_reg_wr, m_mem_alu, m_out_pc} !==
        {1'b1, 1'b0, 5'd18, 1'b1, 2'd3, 32'h304})
      $display("FAIL mul_with_m got v=%b ill=%b alu=%0d wr=%b ma=%0d pc=%h exp v=1 ill=0 alu=18 wr=1 ma=3 pc=304",
               m_out_valid, m_illegal, m_ALUop, m_reg_wr, m_mem_alu, m_out_pc);
    else n_pass++;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h400;
    step();
    in_instr = 32'hFFC12283; in_pc = 32'h404;
    step();
    n_total++;
    if ({skid_valid, in_ready} !== 2'b10)
      $display("FAIL flush_setup got skid=%b rdy=%b exp skid=1 rdy=0", skid_valid, in_ready);
    else n_pass++;
    in_instr = 32'h00512423; in_pc = 32'h408; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_total++;
    if ({out_valid, skid_valid, in_ready} !== 3'b001)
      $display("FAIL flush_full got v=%b skid=%b rdy=%b exp v=0 skid=0 rdy=1", out_valid, skid_valid, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flush_leak cyc=%0d got v=%b pc=%h exp v=0", i, out_valid, out_pc);
      else n_pass++;
    end
    // flush with only M occupied and in_ready high: the offered beat is dropped too
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h410;
    step();
    in_instr = 32'hFFC12283; in_pc = 32'h414; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_total++;
    if ({out_valid, skid_valid, in_ready} !== 3'b001)
      $display("FAIL flush_m_only got v=%b skid=%b rdy=%b exp v=0 skid=0 rdy=1", out_valid, skid_valid, in_ready);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_drop_beat got v=%b pc=%h exp v=0", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h500;
    step();
    in_instr = 32'hFFC12283; in_pc = 32'h504;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, skid_valid} !== 2'b11)
      $display("FAIL areset_setup got v=%b skid=%b exp 11", out_valid, skid_valid);
    else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_total++;
    if ({out_valid, skid_valid, in_ready, ALUop, out_pc} !== {1'b0, 1'b0, 1'b1, 5'd0, 32'd0})
      $display("FAIL areset_immediate got v=%b skid=%b rdy=%b alu=%0d pc=%h exp v=0 skid=0 rdy=1 alu=0 pc=0",
               out_valid, skid_valid, in_ready, ALUop, out_pc);
    else n_pass++;
    #1 reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h508; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, ALUop, imm, alu_src, out_pc} !== {1'b1, 5'd1, 32'hFFFFFFFF, 2'd1, 32'h508})
      $display("FAIL areset_first got v=%b alu=%0d imm=%h src=%0d pc=%h exp v=1 alu=1 imm=ffffffff src=1 pc=508",
               out_valid, ALUop, imm, alu_src, out_pc);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL areset_no_stale got v=%b pc=%h exp v=0", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    logic pend = 1'b0;
    logic [31:0] epc;
    int k;
    exp_q.delete();
    for (int cyc = 0; cyc < 400 && got < N; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && sent < N) pend = ($urandom_range(0, 2) != 0);
      in_valid = pend;
      if (pend) begin
        in_instr = t_instr[sent];
        in_pc    = 32'h600 + 32'(sent << 2);
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra got pc=%h exp=none", out_pc);
        end else begin
          epc = exp_q.pop_front();
          k = int'((epc - 32'h600) >> 2);
          if ({out_pc, ALUop, ctrl, imm, illegal} !== {epc, t_alu[k], t_ctrl[k], t_imm[k], t_ill[k]})
            $display("FAIL stream_%0d got pc=%h alu=%0d ctrl=%b imm=%h ill=%b exp pc=%h alu=%0d ctrl=%b imm=%h ill=%b",
                     k, out_pc, ALUop, ctrl, imm, illegal, epc, t_alu[k], t_ctrl[k], t_imm[k], t_ill[k]);
          else n_pass++;
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_pc);
        sent++;
        pend = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    n_total++;
    if (got != N || exp_q.size() != 0)
      $display("FAIL stream_count got=%0d pending=%0d exp=%0d pending=0", got, exp_q.size(), N);
    else n_pass++;
  endtask

  initial begin
    init_table();
    test_reset();
    test_add();
    test_back_to_back();
    test_branch_mul();
    test_flush();
    test_async_reset();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
